inst_fetch_unit: RTL
====================

// Module: inst_fetch_unit
// PURPOSE
//  - Fetch stage that drives the 1024x32 single-port instruction ROM: generates the ROM address/enable,
//    absorbs the ROM's 1-cycle synchronous read latency, and delivers {inst, inst_pc} on a valid/ready interface.
//  - Sits directly upstream of the instruction ROM (its rom_addr/rom_ena feed addra/ena, rom_douta is douta)
//    and directly upstream of decode. Supports a taken-branch/jump redirect with flush of in-flight fetches.
// PARAMETERS
//  - ADDR_W      10   ROM word-address width; PC wraps modulo 2**ADDR_W
//  - DATA_W      32   instruction width
//  - RESET_ADDR  0    first fetch address after reset
//  - FIFO_DEPTH  2    output instruction buffer entries (>=2; power of 2)
// PORTS
//  - clka           in   1       single clock; ROM shares it
//  - rst            in   1       synchronous reset, active-high
//  - rom_ena        out  1       ROM read enable (one read per cycle when high)
//  - rom_addr       out  ADDR_W  ROM word address
//  - rom_douta      in   DATA_W  ROM data, valid the cycle after rom_ena=1
//  - redirect_valid in   1       load new PC this cycle (priority over everything except rst)
//  - redirect_addr  in   ADDR_W  new fetch address
//  - inst_valid     out  1       buffer head holds an instruction
//  - inst_ready     in   1       decode accepts head; transfer = inst_valid & inst_ready
//  - inst           out  DATA_W  instruction at head
//  - inst_pc        out  ADDR_W  word address inst was fetched from
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc<=RESET_ADDR, buffer emptied, in-flight flag cleared; while rst=1 rom_ena=0,
//    inst_valid=0, inst=0, inst_pc=0. Reset mid-operation discards everything, incl. a ROM read in flight.
//  - State: pc, inflight (1 bit: read issued last cycle), inflight_pc, buffer count/rd/wr pointers.
//  - Issue (combinational): rom_ena = !rst & !redirect_valid & (count + inflight - pop < FIFO_DEPTH),
//    pop = inst_valid & inst_ready; rom_addr = pc. On issue: pc<=pc+1 (wraps 2**ADDR_W-1 -> 0),
//    inflight<=1, inflight_pc<=pc; else inflight<=0.
//  - Return: when inflight=1, rom_douta and inflight_pc are written to buffer tail at the cycle's edge.
//    Credit rule guarantees no overflow; a write and a pop in the same cycle both take effect.
//  - Outputs are registered from the buffer head; inst/inst_pc hold while inst_valid=1 & inst_ready=0.
//  - Latency: issue in cycle N -> data in ROM at N+1 -> inst_valid in N+2. First fetch issues in the
//    first cycle after rst deasserts; inst_valid=1 two cycles later. Steady state: 1 inst/cycle with ready=1.
//  - Redirect in cycle R: buffer flushed and inflight data of R+1 discarded (inflight<=0), pc<=redirect_addr,
//    rom_ena=0 in R; redirect_addr issued in R+1; its inst visible R+3. A pop in R is acknowledged but
//    irrelevant (buffer flushed). Back-to-back redirects: last one wins.
//  - Backpressure: inst_ready=0 with full buffer -> rom_ena=0, pc holds; no instruction lost or duplicated.
//  - Empty: inst_valid=0; inst/inst_pc hold last value (don't-care to consumer).
// CONFIGURATION
//  - FETCH_PERF_EN defined: adds output port fetch_count [31:0], reset 0, +1 per transfer, wraps at 2**32;
//    cleared by rst only (not by redirect).
//  - FETCH_PERF_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  - Reset release, inst_ready=1, ROM[i]=i*4 -> inst_valid first high 2 cycles after rst low; inst_pc 0,1,2,...
//    one per cycle, inst=0,4,8,...
//  - inst_ready low for 5 cycles after 2 insts buffered -> rom_ena=0 during stall; on release, inst_pc resumes
//    with no gap or repeat.
//  - Start at RESET_ADDR=1022 -> inst_pc sequence 1022,1023,0,1 (wrap).
//  - redirect_valid with redirect_addr=100 mid-stream -> no inst from old path after R; next inst_pc=100 at R+3.
//  - rst asserted 1 cycle mid-stream with a read in flight -> inst_valid=0 next cycle, restart at RESET_ADDR,
//    stale data never appears.
//  - FETCH_PERF_EN: 10 transfers with random ready -> fetch_count=10; redirect leaves it unchanged.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage driving a 1-cycle synchronous ROM into a valid/ready buffer
// Optional feature macro: FETCH_PERF_EN (adds the fetch_count transfer counter port).
module inst_fetch_unit #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RESET_ADDR = 0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clka,
    input  logic              rst,
    output logic              rom_ena,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_douta,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
`ifdef FETCH_PERF_EN
    output logic [ADDR_W-1:0] inst_pc,
    output logic [31:0]       fetch_count
`else
    output logic [ADDR_W-1:0] inst_pc
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DATA_W-1:0] buf_inst [FIFO_DEPTH];
    logic [ADDR_W-1:0] buf_pc   [FIFO_DEPTH];

    logic              pop;
    logic              push;
    logic [CNT_W:0]    occupancy;

    // Credit check counts the read in flight so a returning word always has a free slot.
    always_comb begin
        inst_valid = !rst && (count != '0);
        inst       = rst ? '0 : buf_inst[rd_ptr];
        inst_pc    = rst ? '0 : buf_pc[rd_ptr];
        pop        = inst_valid && inst_ready;
        push       = inflight && !redirect_valid;
        occupancy  = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
        rom_ena    = !rst && !redirect_valid && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
        rom_addr   = pc;
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            pc          <= ADDR_W'(RESET_ADDR);
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_addr;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= rom_ena;
            if (rom_ena) begin
                pc          <= pc + 1'b1;
                inflight_pc <= pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clka) begin
        if (!rst && push) begin
            buf_inst[wr_ptr] <= rom_douta;
            buf_pc[wr_ptr]   <= inflight_pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clka) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (pop) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule
